ram_port_ctrl: RTL and testbench
================================

// Module: ram_port_ctrl
// PURPOSE
//  Request/response front-end for the single-port-pair Ram (1-cycle registered read, async-clear).
//  Accepts one read or write per cycle from the CPU pipeline over a valid/ready handshake.
//  Drives the Ram ra/wa/data/we pins, captures ram_result one cycle after each read, and returns
//  read data in order through a 2-entry response buffer so the consumer may stall.
// PARAMETERS
//  ADDR_SIZE  4   width of the Ram address; must match the attached Ram instance
//  CELL_SIZE  16  width of one Ram cell / data bus
// PORTS
//  clk         in   1          clock
//  reset_n     in   1          asynchronous, active-low reset
//  req_valid   in   1          request present
//  req_ready   out  1          request accepted this cycle when req_valid && req_ready
//  req_we      in   1          1 = write, 0 = read
//  req_addr    in   ADDR_SIZE  request address
//  req_wdata   in   CELL_SIZE  write data (ignored for reads)
//  rsp_valid   out  1          read data available
//  rsp_ready   in   1          consumer takes the response when rsp_valid && rsp_ready
//  rsp_rdata   out  CELL_SIZE  read data, in request order
//  ram_ra      out  ADDR_SIZE  to Ram.ra
//  ram_wa      out  ADDR_SIZE  to Ram.wa
//  ram_data    out  CELL_SIZE  to Ram.data
//  ram_we      out  1          to Ram.we
//  ram_result  in   CELL_SIZE  from Ram.result (valid the cycle after ra is presented)
// BEHAVIOUR
//  - Reset (async): inflight=0, occupancy=0, rsp_valid=0, rsp_rdata=0; req_ready=1 after reset.
//  - ram_ra = ram_wa = req_addr, ram_data = req_wdata (combinational, always).
//  - ram_we = req_valid && req_ready && req_we (combinational); writes produce no response.
//  - Write acceptance: req_ready=1 for writes unconditionally (no response slot needed).
//  - Read acceptance: req_ready = (occ + inflight - pop) < 2, pop = rsp_valid && rsp_ready.
//    req_ready may depend on req_we and rsp_ready combinationally; never on itself.
//  - inflight register: set at the edge ending a read-accept cycle, else cleared.
//  - Cycle with inflight=1: ram_result pushed into response buffer at the following edge.
//  - Latency: read accepted in cycle N -> rsp_valid in cycle N+2 (buffer registered, no bypass).
//  - Throughput: one read per cycle sustained while rsp_ready=1.
//  - Buffer: 2-entry FIFO, occ 0..2; push and pop in same cycle allowed at any occ (occ unchanged
//    at 1 or 2; at 0 push only, pop impossible). Overflow impossible by the ready rule; assert it.
//  - rsp_valid = (occ != 0); rsp_rdata = head entry; held stable while rsp_valid && !rsp_ready.
//  - Ordering: write then read of same address on next cycle returns the new data (Ram writes at
//    the accept edge). Only one request per cycle, so no same-cycle RAW exists.
//  - Reset mid-operation: in-flight read and buffered responses discarded, no response ever
//    emitted for them; Ram clears concurrently, so post-reset reads return 0.
// STRUCTURE
//  - Package ram_pkg: ADDR_SIZE/CELL_SIZE defaults, typedef struct ram_req_t {we, addr, wdata},
//    localparam RSP_DEPTH = 2.
//  - Sub-module ram_rsp_fifo (depth 2, CELL_SIZE wide, push/pop/occ/head, async-clear).
//  - Top holds inflight flag, ready logic and Ram pin muxing.
// TESTING (bench instantiates ram_port_ctrl + Ram)
//  1. reset_n low 3 cycles -> rsp_valid=0, ram_we=0, req_ready=1; release -> still idle.
//  2. Write 0xBEEF @3, next cycle read @3 -> rsp_valid exactly 2 cycles after read accept,
//     rsp_rdata=0xBEEF.
//  3. rsp_ready=1, reads @0..@7 back-to-back after writing addr*0x1111 -> 8 responses on 8
//     consecutive cycles, data 0x0000..0x7777 in order, req_ready never drops.
//  4. rsp_ready=0, read @1,@2,@3 -> two accepted, req_ready=0 holding @3, rsp_rdata stable;
//     raise rsp_ready -> @1,@2,@3 data delivered in order.
//  5. With buffer full (occ=2), write 0x1234 @5 -> accepted same cycle, ram_we=1, no response;
//     later read @5 -> 0x1234.
//  6. Buffer holding 2 responses, pulse reset_n low mid-cycle -> rsp_valid=0 immediately;
//     after release read @3 -> 0x0000, no stale responses appear.

Source files
------------

// File: rtl/ram_pkg.sv
// ============================================================================
// ram_pkg: shared sizes and request type for the Ram port controller.
// Revision: 1.0
// ============================================================================
`default_nettype none

package ram_pkg;

   localparam int ADDR_SIZE = 4;
   localparam int CELL_SIZE = 16;
   localparam int RSP_DEPTH = 2;

   typedef struct packed {
      logic                 we;
      logic [ADDR_SIZE-1:0] addr;
      logic [CELL_SIZE-1:0] wdata;
   } ram_req_t;

endpackage

`default_nettype wire

// File: rtl/ram_rsp_fifo.sv
// ============================================================================
// ram_rsp_fifo: 2-entry response FIFO with async clear.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ram_rsp_fifo
   import ram_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic [WIDTH-1:0] i_data,
   output logic [1:0]       o_occ,
   output logic [WIDTH-1:0] o_head
);

   logic [WIDTH-1:0] r_mem [RSP_DEPTH];
   logic             r_wr_ptr;
   logic             r_rd_ptr;
   logic [1:0]       r_occ;
   logic             w_pop_ok;

   // Popping an empty FIFO is ignored so the pointers cannot drift.
   assign w_pop_ok = i_pop && (r_occ != 2'd0);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < RSP_DEPTH; i++) begin
            r_mem[i] <= '0;
         end
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_occ    <= 2'd0;
      end else begin
         if (i_push) begin
            r_mem[r_wr_ptr] <= i_data;
            r_wr_ptr        <= ~r_wr_ptr;
         end
         if (w_pop_ok) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         case ({i_push, w_pop_ok})
            2'b10:   r_occ <= r_occ + 2'd1;
            2'b01:   r_occ <= r_occ - 2'd1;
            default: r_occ <= r_occ;
         endcase
      end
   end

   assign o_occ  = r_occ;
   assign o_head = r_mem[r_rd_ptr];

   a_no_overflow : assert property (@(posedge clk) disable iff (!reset_n)
      !(i_push && !w_pop_ok && (r_occ == 2'd2)));

endmodule

`default_nettype wire

// File: rtl/ram_port_ctrl.sv
// ============================================================================
// ram_port_ctrl: valid/ready front-end driving a 1-cycle registered-read Ram.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ram_port_ctrl
   import ram_pkg::*;
#(
   parameter int ADDR_SIZE = ram_pkg::ADDR_SIZE,
   parameter int CELL_SIZE = ram_pkg::CELL_SIZE
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 i_req_valid,
   output logic                 o_req_ready,
   input  logic                 i_req_we,
   input  logic [ADDR_SIZE-1:0] i_req_addr,
   input  logic [CELL_SIZE-1:0] i_req_wdata,
   output logic                 o_rsp_valid,
   input  logic                 i_rsp_ready,
   output logic [CELL_SIZE-1:0] o_rsp_rdata,
   output logic [ADDR_SIZE-1:0] o_ram_ra,
   output logic [ADDR_SIZE-1:0] o_ram_wa,
   output logic [CELL_SIZE-1:0] o_ram_data,
   output logic                 o_ram_we,
   input  logic [CELL_SIZE-1:0] i_ram_result
);

   logic                 r_inflight;
   logic [1:0]           w_occ;
   logic [CELL_SIZE-1:0] w_head;
   logic                 w_pop;
   logic [2:0]           w_pending;
   logic                 w_ready;
   logic                 w_read_acc;

   assign w_pop = (w_occ != 2'd0) && i_rsp_ready;

   // A read needs a buffer slot guaranteed for when its data lands two
   // cycles later; writes never produce a response so are always taken.
   assign w_pending  = {1'b0, w_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
   assign w_ready    = i_req_we || (w_pending < 3'(RSP_DEPTH));
   assign w_read_acc = i_req_valid && w_ready && !i_req_we;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_inflight <= 1'b0;
      end else begin
         r_inflight <= w_read_acc;
      end
   end

   ram_rsp_fifo #(
      .WIDTH (CELL_SIZE)
   ) u_rsp_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .i_push  (r_inflight),
      .i_pop   (w_pop),
      .i_data  (i_ram_result),
      .o_occ   (w_occ),
      .o_head  (w_head)
   );

   assign o_req_ready = w_ready;
   assign o_rsp_valid = (w_occ != 2'd0);
   assign o_rsp_rdata = w_head;

   assign o_ram_ra   = i_req_addr;
   assign o_ram_wa   = i_req_addr;
   assign o_ram_data = i_req_wdata;
   assign o_ram_we   = i_req_valid && w_ready && i_req_we;

endmodule

`default_nettype wire

// File: tb/tb_ram_port_ctrl.sv
// ============================================================================
// tb_ram_port_ctrl: scoreboard bench for ram_port_ctrl with a behavioural Ram.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ram_port_ctrl;

   localparam int AW = 4;
   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          req_valid, req_ready, req_we;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata;
   logic          rsp_valid, rsp_ready;
   logic [DW-1:0] rsp_rdata;
   logic [AW-1:0] ram_ra, ram_wa;
   logic [DW-1:0] ram_data, ram_result;
   logic          ram_we;

   always #5 clk = ~clk;

   ram_port_ctrl #(
      .ADDR_SIZE (AW),
      .CELL_SIZE (DW)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .i_req_valid  (req_valid),
      .o_req_ready  (req_ready),
      .i_req_we     (req_we),
      .i_req_addr   (req_addr),
      .i_req_wdata  (req_wdata),
      .o_rsp_valid  (rsp_valid),
      .i_rsp_ready  (rsp_ready),
      .o_rsp_rdata  (rsp_rdata),
      .o_ram_ra     (ram_ra),
      .o_ram_wa     (ram_wa),
      .o_ram_data   (ram_data),
      .o_ram_we     (ram_we),
      .i_ram_result (ram_result)
   );

   // Behavioural Ram: write at the edge, registered read, async clear.
   logic [DW-1:0] ram_mem [16];
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 16; i++) ram_mem[i] <= '0;
         ram_result <= '0;
      end else begin
         if (ram_we) ram_mem[ram_wa] <= ram_data;
         ram_result <= ram_mem[ram_ra];
      end
   end

   int            n_checks = 0;
   int            n_pass   = 0;
   int            cyc      = 0;
   logic [DW-1:0] exp_q [$];
   int            pop_cyc [$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
   endtask

   // Monitor: every response handed over is compared against the queue head.
   always @(negedge clk) begin
      if (reset_n && rsp_valid && rsp_ready) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_rsp: got 0x%0h expected no response (t=%0t)", rsp_rdata, $time);
         end else begin
            check("rsp_data", {16'h0, rsp_rdata}, {16'h0, exp_q.pop_front()});
            pop_cyc.push_back(cyc);
         end
      end
   end

   // Called at posedge+1; returns at posedge+1 of the cycle after acceptance.
   task automatic send(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                       input logic [DW-1:0] exp, output int waits, output logic we_seen);
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = addr;
      req_wdata = wd;
      waits     = 0;
      @(negedge clk);
      while (!req_ready && waits < 20) begin
         waits++;
         @(negedge clk);
      end
      we_seen = ram_we;
      if (!req_ready) begin
         n_checks++;
         $display("FAIL send_timeout: req_ready 0 expected 1 for addr %0d", addr);
      end else if (!we) begin
         exp_q.push_back(exp);
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   int            w, wsum;
   logic          s;
   logic [DW-1:0] held;

   initial begin
      reset_n   = 1'b0;
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      rsp_ready = 1'b0;

      // 1: reset state and idle after release
      repeat (3) begin
         @(negedge clk);
         check("rst_rsp_valid", rsp_valid, 0);
         check("rst_ram_we", ram_we, 0);
         check("rst_req_ready", req_ready, 1);
      end
      @(posedge clk); #1;
      reset_n = 1'b1;
      @(negedge clk);
      check("post_rst_rsp_valid", rsp_valid, 0);
      check("post_rst_req_ready", req_ready, 1);
      idle(1);

      // 2: write then read same address, exact 2-cycle latency
      rsp_ready = 1'b1;
      send(1'b1, 4'd3, 16'hBEEF, 16'h0, w, s);
      check("wr_ram_we", s, 1);
      send(1'b0, 4'd3, 16'h0, 16'hBEEF, w, s);
      @(negedge clk);
      check("lat_n1_rsp_valid", rsp_valid, 0);
      @(negedge clk);
      check("lat_n2_rsp_valid", rsp_valid, 1);
      idle(3);

      // 3: streaming reads at full rate
      for (int i = 0; i < 8; i++) send(1'b1, 4'(i), 16'(i * 16'h1111), 16'h0, w, s);
      pop_cyc.delete();
      wsum = 0;
      for (int i = 0; i < 8; i++) begin
         send(1'b0, 4'(i), 16'h0, 16'(i * 16'h1111), w, s);
         wsum += w;
      end
      idle(4);
      check("stream_stalls", wsum, 0);
      check("stream_count", pop_cyc.size(), 8);
      if (pop_cyc.size() == 8) check("stream_span", pop_cyc[7] - pop_cyc[0], 7);

      // 4: consumer stall, third read held off until space frees
      rsp_ready = 1'b0;
      fork
         begin
            send(1'b0, 4'd1, 16'h0, 16'h1111, w, s);
            send(1'b0, 4'd2, 16'h0, 16'h2222, w, s);
            send(1'b0, 4'd3, 16'h0, 16'h3333, w, s);
         end
         begin
            repeat (5) @(negedge clk);
            check("stall_req_ready", req_ready, 0);
            check("stall_rsp_valid", rsp_valid, 1);
            held = rsp_rdata;
            check("stall_head", held, 16'h1111);
            @(negedge clk);
            check("stall_head_stable", rsp_rdata, held);
            @(posedge clk); #1;
            rsp_ready = 1'b1;
         end
      join
      check("stall_waited", (w > 0), 1);
      idle(4);

      // 5: write accepted while the buffer is full
      rsp_ready = 1'b0;
      send(1'b0, 4'd1, 16'h0, 16'h1111, w, s);
      send(1'b0, 4'd2, 16'h0, 16'h2222, w, s);
      idle(2);
      send(1'b1, 4'd5, 16'h1234, 16'h0, w, s);
      check("full_wr_wait", w, 0);
      check("full_wr_ram_we", s, 1);
      idle(3);
      check("full_pending", exp_q.size(), 2);
      rsp_ready = 1'b1;
      idle(3);
      send(1'b0, 4'd5, 16'h0, 16'h1234, w, s);
      idle(4);

      // 6: reset with two buffered responses
      rsp_ready = 1'b0;
      send(1'b0, 4'd1, 16'h0, 16'h1111, w, s);
      send(1'b0, 4'd2, 16'h0, 16'h2222, w, s);
      idle(2);
      check("pre_rst_rsp_valid", rsp_valid, 1);
      #3;
      reset_n = 1'b0;
      #1;
      check("mid_rst_rsp_valid", rsp_valid, 0);
      check("mid_rst_req_ready", req_ready, 1);
      exp_q.delete();
      @(posedge clk); #1;
      reset_n   = 1'b1;
      rsp_ready = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("post_rst_idle", rsp_valid, 0);
      end
      @(posedge clk); #1;
      send(1'b0, 4'd3, 16'h0, 16'h0000, w, s);
      idle(5);

      check("queue_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule

`default_nettype wire
